// File: rtl/sound_source_arbiter.sv
// Round-robin arbiter sharing one DAC sample path among n_src producers, one grant per sample strobe.
// Define SOUND_SOURCE_ARBITER_HOLD_EN to let a winner keep the path for up to hold_samples samples.
module sound_source_arbiter #(
  parameter int clk_mhz        = 27,
  parameter int sample_rate_hz = 48000,
  parameter int n_src          = 4,
  parameter int w_sample       = 16,
  parameter int hold_samples   = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [n_src-1:0]            src_req,
  input  logic [n_src*w_sample-1:0]   src_data,
  output logic [n_src-1:0]            src_ack,
  output logic [w_sample-1:0]         sound,
  output logic [$clog2(n_src)-1:0]    grant_idx,
  output logic                        sample_stb,
  output logic                        busy
);

  localparam int PERIOD = (clk_mhz * 1_000_000) / sample_rate_hz;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW     = $clog2(n_src);

  if (n_src < 2 || hold_samples < 1 || PERIOD < 1) begin : g_bad_cfg
    $error("sound_source_arbiter: invalid parameter set");
  end

  logic [CW-1:0]       r_cnt;
  logic                w_tick;
  logic [IW-1:0]       r_last;
  logic                w_found;
  logic [IW-1:0]       w_win;
  logic                w_serve;
  logic [IW-1:0]       w_serve_idx;
  logic [w_sample-1:0] w_sel;
  logic [w_sample-1:0] r_sound;
  logic [n_src-1:0]    r_ack;
  logic [IW-1:0]       r_grant;
  logic                r_stb;

  assign w_tick = (r_cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // Search starts just after the last grant; while a burst is held, last equals the owner.
  always_comb begin : p_search
    int            j;
    logic [IW-1:0] v_idx;
    j       = 0;
    v_idx   = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= n_src; k++) begin
      j     = (int'(r_last) + k) % n_src;
      v_idx = IW'(j);
      if (!w_found && src_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

`ifdef SOUND_SOURCE_ARBITER_HOLD_EN
  localparam int HW = $clog2(hold_samples + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic          w_keep;

  assign w_keep      = (r_state == OWN) && src_req[r_last] && (r_hold_cnt < HW'(hold_samples));
  assign w_serve     = w_tick && (w_keep || w_found);
  assign w_serve_idx = w_keep ? r_last : w_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else if (w_tick) begin
      if (w_keep) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else if (w_found) begin
        r_state    <= OWN;
        r_hold_cnt <= HW'(1);
      end else begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
      end
    end
  end

  assign busy = (r_state == OWN);
`else
  assign w_serve     = w_tick && w_found;
  assign w_serve_idx = w_win;
  assign busy        = |r_ack;
`endif

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < n_src; k++) begin
      if (IW'(k) == w_serve_idx) w_sel = src_data[k*w_sample +: w_sample];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sound <= '0;
      r_ack   <= '0;
      r_grant <= '0;
      r_stb   <= 1'b0;
      r_last  <= IW'(n_src - 1);
    end else begin
      r_stb <= w_tick;
      r_ack <= '0;
      if (w_tick) begin
        if (w_serve) begin
          r_sound <= w_sel;
          r_ack   <= {{(n_src-1){1'b0}}, 1'b1} << w_serve_idx;
          r_grant <= w_serve_idx;
          r_last  <= w_serve_idx;
        end else begin
          r_sound <= '0;
        end
      end
    end
  end

  assign src_ack    = r_ack;
  assign sound      = r_sound;
  assign grant_idx  = r_grant;
  assign sample_stb = r_stb;

endmodule
